edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
//
// PURPOSE
//  Detects edges on WIDTH asynchronous-free (already synchronised) event lines, latches each
//  as a pending request and serialises them onto one valid/ready event stream, round-robin.
//  Sits between the edge-detect front end and the single interrupt/event consumer (CPU
//  event FIFO or sequencer), so simultaneous edges are never lost and each channel gets fair service.
//
// PARAMETERS
//  WIDTH      8   number of event channels, 2..32
//  EDGE_MODE  0   0 = rising, 1 = falling, 2 = both edges, applied to all channels
//  IDX_W      localparam = $clog2(WIDTH), width of ev_idx
//
// PORTS
//  clk          in   1        clock
//  anrst        in   1        reset, asynchronous, active-low
//  in           in   WIDTH    event lines, synchronous to clk
//  mask         in   WIDTH    1 = channel capture enabled
//  ev_valid     out  1        event output valid
//  ev_ready     in   1        consumer accepts event when ev_valid & ev_ready
//  ev_idx       out  IDX_W    channel index of presented event
//  pending      out  WIDTH    latched, not yet presented events
//  overrun      out  WIDTH    sticky: edge arrived while channel already pending
//  overrun_clr  in   WIDTH    per-bit clear of overrun
//  irq          out  1        |pending | ev_valid
//
// BEHAVIOUR
//  - Reset (anrst=0, async): in_d, pending, overrun, ev_valid, ev_idx = 0; rr pointer = WIDTH-1;
//    all outputs 0 immediately, regardless of clk. Reset mid-transfer drops the event silently.
//  - Edge vector e (comb): mode0 in&~in_d, mode1 ~in&in_d, mode2 in^in_d; then & mask.
//    in_d resets to 0, so a line high at reset release yields a rising edge on first clk.
//  - pending[i] next = (pending[i] & ~grant[i]) | e[i]; same-cycle edge and grant -> stays 1.
//  - overrun[i] next = (overrun[i] & ~overrun_clr[i]) | (e[i] & pending[i] & ~grant[i]);
//    set wins over clear. Overrun events merge into the single pending bit.
//  - mask gates capture only; already-pending bits of a masked channel are still served.
//  - Load condition: load = ~ev_valid | ev_ready. When load and |pending: pick first set bit
//    of pending searching from rr+1 upward with wrap to 0; grant[that]=1; ev_idx<=idx;
//    ev_valid<=1; rr<=idx. When load and pending==0: ev_valid<=0, ev_idx holds.
//  - Arbitration uses registered pending only (no bypass of this cycle's edge).
//  - Latency: edge visible on in in cycle N -> pending set cycle N+1 -> ev_valid cycle N+2.
//  - Throughput: one event per cycle with ev_ready held high.
//  - Handshake: while ev_valid & ~ev_ready, ev_idx and ev_valid hold stable; no new grant;
//    consumer may not rely on ev_ready being low before ev_valid.
//  - rr pointer updates only on grant; after reset channel 0 has highest priority.
//  - Two FSM-free registered stages; no combinational path from in to ev_* outputs.
//  - ev_ready when ev_valid=0 has no effect.
//
// TESTING
//  1 Reset, WIDTH=8, mask=FF, in rises bit3 at N, ready=1 -> pending=08 at N+1,
//    ev_valid=1 ev_idx=3 at N+2 only, pending=00 at N+2.
//  2 in=00->FF in one cycle, ready=1 -> ev_idx 0,1,..,7 on 8 consecutive cycles, then valid=0.
//  3 ready=0, edges on ch2,ch5 -> valid with idx=2 held stable >=10 cycles; raise ready ->
//    idx=2 accepted, next cycle idx=5.
//  4 ch4 pending & ready=0, second rising edge ch4 -> overrun=10, only one ch4 event delivered;
//    overrun_clr=10 with no new edge -> overrun=00; clr and new overrun same cycle -> stays 10.
//  5 mask=00, toggle all lines -> no pending/valid; rr fairness: ch1 granted, then ch0 & ch1
//    pending together -> ch0 served before ch1.
//  6 anrst low mid-stall (valid=1) -> valid, pending, overrun, irq 0 asynchronously;
//    after release with in held high (mode0) -> events for every high line.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Captures edges on WIDTH synchronised event lines into per-channel pending
// bits and serialises them round-robin onto a single valid/ready stream.
// Stage 1: edge detect + pending/overrun capture.
// Stage 2: round-robin pick from registered pending into the output register.
// No combinational path exists from in to the ev_* outputs.
module edge_event_arbiter #(
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = 0,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] mask,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_idx,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overrun,
  input  logic [WIDTH-1:0] overrun_clr,
  output logic             irq
);

  // Registered state
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic [WIDTH-1:0] overrun_q;
  logic [WIDTH-1:0] overrun_d;
  logic             ev_valid_q;
  logic             ev_valid_d;
  logic [IDX_W-1:0] ev_idx_q;
  logic [IDX_W-1:0] ev_idx_d;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;

  // Combinational helpers
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] grant;
  logic             load;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;

  // Per-channel edge detector; the polarity is fixed at elaboration.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    if (EDGE_MODE == 0) begin : g_rise
      assign edge_raw[gi] = in[gi] & ~in_q[gi];
    end else if (EDGE_MODE == 1) begin : g_fall
      assign edge_raw[gi] = ~in[gi] & in_q[gi];
    end else begin : g_both
      assign edge_raw[gi] = in[gi] ^ in_q[gi];
    end
  end

  // Mask gates capture only; bits already pending keep being served.
  assign edge_hit = edge_raw & mask;

  // The output register may take a new event when empty or being accepted.
  assign load = ~ev_valid_q | ev_ready;

  // Round-robin search: first pending bit strictly after rr, wrapping to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      cand_idx = IDX_W'((int'(rr_q) + k) % WIDTH);
      if (!pick_found && pending_q[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state for grant, pending, overrun, output register and rr pointer.
  always_comb begin
    grant      = '0;
    ev_valid_d = ev_valid_q;
    ev_idx_d   = ev_idx_q;
    rr_d       = rr_q;
    if (load) begin
      if (pick_found) begin
        grant[pick_idx] = 1'b1;
        ev_valid_d      = 1'b1;
        ev_idx_d        = pick_idx;
        rr_d            = pick_idx;
      end else begin
        // Nothing to present: drop valid, keep the last index.
        ev_valid_d = 1'b0;
      end
    end
    // A fresh edge in the same cycle as its grant re-arms the channel.
    pending_d = (pending_q & ~grant) | edge_hit;
    // Setting wins over clearing so a simultaneous overrun is never lost.
    overrun_d = (overrun_q & ~overrun_clr) | (edge_hit & pending_q & ~grant);
  end

  // State registers with asynchronous active-low reset; rr starts at the top
  // so channel 0 has highest priority after reset.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      in_q       <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      ev_valid_q <= 1'b0;
      ev_idx_q   <= '0;
      rr_q       <= IDX_W'(WIDTH - 1);
    end else begin
      in_q       <= in;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      ev_valid_q <= ev_valid_d;
      ev_idx_q   <= ev_idx_d;
      rr_q       <= rr_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_idx   = ev_idx_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;
  assign irq      = (|pending_q) | ev_valid_q;

endmodule
